uart_rx_frame_ctrl: RTL and testbench

- UART receive frame controller and deserializer for the rx_clk domain.
- Sits beside the edge/bit counter stage. It drives that stage's counter_enable and deserializer_enable, and consumes its edge_done_tick, data_done_tick and sampling_tick.
- Majority-votes three mid-bit samples per bit and tracks start/data/parity/stop. Emits the received byte with a one-cycle valid pulse and per-frame error pulses to the register file.

---
 rtl/uart_rx_frame_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// UART receive frame controller and deserializer in the rx_clk domain.
// Works alongside an external edge/bit counter stage: this block enables
// that stage and consumes its ticks. It majority-votes three mid-bit
// samples per bit, walks start/data/parity/stop, and reports each frame
// with a one-cycle pulse.
//
// Ports:
//   rx_clk              receive (oversampling) clock
//   rst                 synchronous reset, active-high
//   rx_in               synchronized serial line, idles high
//   parity_enable       1 = frame carries a parity bit
//   parity_type         0 = even, 1 = odd
//   edge_done_tick      last oversample edge of the current bit
//   data_done_tick      bit counter is on the final data bit
//   sampling_tick       one of the three mid-bit sample edges
//   counter_enable      run the edge counter (any state but IDLE)
//   deserializer_enable advance the data bit counter (DATA only)
//   p_data              last good received byte
//   data_valid          one-cycle pulse, p_data updated
//   parity_error        one-cycle pulse, parity mismatch
//   stop_error          one-cycle pulse, stop bit sampled low
//   busy                frame in progress
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                  rx_clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  input  logic                  edge_done_tick,
  input  logic                  data_done_tick,
  input  logic                  sampling_tick,
  output logic                  counter_enable,
  output logic                  deserializer_enable,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  // The prescale field only travels with this block; it must at least be
  // wide enough to hold the minimum prescale of 8.
  if (PRESCALE_WIDTH < 4) begin : g_prescale_too_narrow
  end

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  state_e                state_q, state_d;
  logic [2:0]            samp_q, samp_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_type_q, par_type_d;
  logic                  par_err_q, par_err_d;
  logic                  dv_q, dv_d;
  logic                  pe_q, pe_d;
  logic                  se_q, se_d;
  logic                  bit_val_s;
  logic                  stop_bad_s;

  // Vote over the three samples of the current bit.
  assign bit_val_s = maj3(samp_q);

  // Moore decode of the state register.
  assign counter_enable      = (state_q != IDLE);
  assign deserializer_enable = (state_q == DATA);
  assign busy                = (state_q != IDLE);
  assign p_data              = p_data_q;
  assign data_valid          = dv_q;
  assign parity_error        = pe_q;
  assign stop_error          = se_q;

  // Next-state, sampler, shifter and pulse logic.
  always_comb begin
    state_d    = state_q;
    samp_d     = samp_q;
    shreg_d    = shreg_q;
    p_data_d   = p_data_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    par_err_d  = par_err_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;
    stop_bad_s = 1'b0;

    // Sample ticks only matter once the edge counter is running.
    if (counter_enable && sampling_tick) begin
      samp_d = {samp_q[1:0], rx_in};
    end else begin
      samp_d = samp_q;
    end

    case (state_q)
      IDLE: begin
        if (!rx_in) begin
          // Freeze the frame format so mid-frame config writes are harmless.
          state_d    = START;
          samp_d     = 3'b000;
          par_en_d   = parity_enable;
          par_type_d = parity_type;
          par_err_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (edge_done_tick) begin
          // A start bit that votes high was a line glitch.
          state_d = bit_val_s ? IDLE : DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (edge_done_tick) begin
          shreg_d = {bit_val_s, shreg_q[DATA_WIDTH-1:1]};
          if (data_done_tick) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (edge_done_tick) begin
          par_err_d = bit_val_s != ((^shreg_q) ^ par_type_q);
          state_d   = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (edge_done_tick) begin
          stop_bad_s = ~bit_val_s;
          pe_d       = par_err_q;
          se_d       = stop_bad_s;
          dv_d       = ~stop_bad_s & ~par_err_q;
          if (dv_d) begin
            p_data_d = shreg_q;
          end else begin
            p_data_d = p_data_q;
          end
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      samp_q     <= 3'b000;
      shreg_q    <= '0;
      p_data_q   <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      par_err_q  <= 1'b0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      samp_q     <= samp_d;
      shreg_q    <= shreg_d;
      p_data_q   <= p_data_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      par_err_q  <= par_err_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl. The bench plays the part of the
// edge/bit counter stage: each bit lasts 'p' cycles, sample ticks sit on
// cycles p/2-1..p/2+1 and edge_done_tick on cycle p-1.
module tb_uart_rx_frame_ctrl;

  logic       rx_clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       parity_enable;
  logic       parity_type;
  logic       edge_done_tick;
  logic       data_done_tick;
  logic       sampling_tick;
  logic       counter_enable;
  logic       deserializer_enable;
  logic [7:0] p_data;
  logic       data_valid;
  logic       parity_error;
  logic       stop_error;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int dv_cnt = 0;
  int pe_cnt = 0;
  int se_cnt = 0;
  logic [7:0] rx_q[$];
  int dv0, pe0, se0, q0;

  uart_rx_frame_ctrl #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .rx_clk(rx_clk), .rst(rst), .rx_in(rx_in),
    .parity_enable(parity_enable), .parity_type(parity_type),
    .edge_done_tick(edge_done_tick), .data_done_tick(data_done_tick),
    .sampling_tick(sampling_tick), .counter_enable(counter_enable),
    .deserializer_enable(deserializer_enable), .p_data(p_data),
    .data_valid(data_valid), .parity_error(parity_error),
    .stop_error(stop_error), .busy(busy)
  );

  always #5 rx_clk = ~rx_clk;

  // Count every high cycle of each pulse output and log delivered bytes.
  always @(negedge rx_clk) begin
    if (data_valid) begin
      dv_cnt <= dv_cnt + 1;
      rx_q.push_back(p_data);
    end
    if (parity_error) pe_cnt <= pe_cnt + 1;
    if (stop_error) se_cnt <= se_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rxv, input logic samp, input logic edge_t, input logic dd);
    @(negedge rx_clk);
    rx_in          = rxv;
    sampling_tick  = samp;
    edge_done_tick = edge_t;
    data_done_tick = dd;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bit(input logic v, input int p, input logic last_data, input int glitch_cyc);
    for (int c = 0; c < p; c++) begin
      step((c == glitch_cyc) ? ~v : v,
           (c >= p/2 - 1) && (c <= p/2 + 1),
           c == p - 1,
           last_data && (c == p - 1));
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input int p, input logic par_bit,
                            input logic stop_bit, input int glitch_bit, input int glitch_cyc);
    send_bit(1'b0, p, 1'b0, -1);
    for (int i = 0; i < 8; i++) begin
      send_bit(data[i], p, i == 7, (i == glitch_bit) ? glitch_cyc : -1);
    end
    if (parity_enable) send_bit(par_bit, p, 1'b0, -1);
    send_bit(stop_bit, p, 1'b0, -1);
  endtask

  task automatic snap();
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt; q0 = rx_q.size();
  endtask

  task automatic chk_counts(input string tag, input int dv, input int pe, input int se);
    chk({tag, "_dv"}, 32'(dv_cnt - dv0), 32'(dv));
    chk({tag, "_pe"}, 32'(pe_cnt - pe0), 32'(pe));
    chk({tag, "_se"}, 32'(se_cnt - se0), 32'(se));
  endtask

  initial begin
    rst = 1'b1; rx_in = 1'b1; parity_enable = 1'b0; parity_type = 1'b0;
    edge_done_tick = 1'b0; data_done_tick = 1'b0; sampling_tick = 1'b0;
    repeat (3) @(negedge rx_clk);
    chk("rst_cnt_en", 32'(counter_enable), 32'd0);
    chk("rst_deser_en", 32'(deserializer_enable), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_p_data", 32'(p_data), 32'h00);
    chk("rst_pulses", 32'({data_valid, parity_error, stop_error}), 32'd0);
    rst = 1'b0;
    idle(2);

    // 0xA5, no parity, prescale 8: pulse exactly one cycle after stop edge.
    snap();
    send_frame(8'hA5, 8, 1'b0, 1'b1, -1, -1);
    idle(1);
    chk("t1_dv_at_lat1", 32'(data_valid), 32'd1);
    chk("t1_p_data", 32'(p_data), 32'hA5);
    chk("t1_busy_after", 32'(busy), 32'd0);
    idle(1);
    chk("t1_dv_one_cycle", 32'(data_valid), 32'd0);
    idle(2);
    chk_counts("t1", 1, 0, 0);

    // Even parity, correct then wrong parity bit.
    parity_enable = 1'b1; parity_type = 1'b0;
    snap();
    send_frame(8'hA5, 8, 1'b0, 1'b1, -1, -1);
    idle(3);
    chk_counts("t2a", 1, 0, 0);
    chk("t2a_p_data", 32'(p_data), 32'hA5);
    snap();
    send_frame(8'hA5, 8, 1'b1, 1'b1, -1, -1);
    idle(3);
    chk_counts("t2b", 0, 1, 0);
    chk("t2b_p_data_hold", 32'(p_data), 32'hA5);

    // Odd parity correct, stop bit low, prescale 16.
    parity_type = 1'b1;
    snap();
    send_frame(8'h3C, 16, 1'b1, 1'b0, -1, -1);
    idle(3);
    chk_counts("t3", 0, 0, 1);
    chk("t3_p_data_hold", 32'(p_data), 32'hA5);

    // False start: line low for two cycles only.
    parity_enable = 1'b0; parity_type = 1'b0;
    snap();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_busy_in_start", 32'(busy), 32'd1);
    for (int c = 2; c < 8; c++) step(1'b1, (c >= 3) && (c <= 5), c == 7, 1'b0);
    idle(1);
    chk("t4_cnt_en_off", 32'(counter_enable), 32'd0);
    chk("t4_busy_off", 32'(busy), 32'd0);
    idle(3);
    chk_counts("t4", 0, 0, 0);

    // 0xFF with a one-cycle low glitch on each sample slot of data bit 3.
    snap();
    for (int k = 0; k < 3; k++) begin
      send_frame(8'hFF, 8, 1'b0, 1'b1, 3, 3 + k);
      idle(2);
    end
    idle(1);
    chk_counts("t5", 3, 0, 0);
    chk("t5_p_data", 32'(p_data), 32'hFF);

    // Reset during data bit 4, then a clean 0x5A frame.
    snap();
    send_bit(1'b0, 8, 1'b0, -1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 8, 1'b0, -1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_deser_en_in_data", 32'(deserializer_enable), 32'd1);
    @(negedge rx_clk);
    rst = 1'b1;
    @(negedge rx_clk);
    rst = 1'b0; rx_in = 1'b1;
    chk("t6_cnt_en_after_rst", 32'(counter_enable), 32'd0);
    chk("t6_busy_after_rst", 32'(busy), 32'd0);
    idle(12);
    chk_counts("t6_abort", 0, 0, 0);
    send_frame(8'h5A, 8, 1'b0, 1'b1, -1, -1);
    idle(3);
    chk_counts("t6", 1, 0, 0);
    chk("t6_p_data", 32'(p_data), 32'h5A);

    // Back-to-back frames with no idle gap.
    snap();
    send_frame(8'h11, 8, 1'b0, 1'b1, -1, -1);
    send_frame(8'h22, 8, 1'b0, 1'b1, -1, -1);
    idle(3);
    chk_counts("t7", 2, 0, 0);
    chk("t7_q_len", 32'(rx_q.size() - q0), 32'd2);
    if (rx_q.size() >= q0 + 2) begin
      chk("t7_first", 32'(rx_q[q0]), 32'h11);
      chk("t7_second", 32'(rx_q[q0 + 1]), 32'h22);
    end else begin
      chk("t7_q_present", 32'(rx_q.size()), 32'(q0 + 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
